gcd_stein: RTL and testbench

Parametrised successor to the team's fixed 32-bit `gcd` unit. It computes the greatest common divisor of two unsigned `WIDTH`-bit operands with Stein's binary algorithm, one step per clock, using only shifts, compares and subtracts. The port behaviour is compatible with the existing start/done bench: pulse `start`, wait for `done`, then sample `result`. Added behaviour: defined zero-operand handling with an error flag, a `busy` indication, and an optional performance counter.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_stein_step.sv | 30 +++
 rtl/gcd_stein.sv | 117 +++++++++++
 tb/tb_gcd_stein.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd_stein binary-GCD unit.
package gcd_pkg;

    localparam int CYCLES_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STRIP  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } gcd_state_t;

endpackage

// File: rtl/gcd_stein_step.sv
// One Stein reduction step: maps (a, b) to the next (a, b) and flags equality.
module gcd_stein_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic             equal
);

    always_comb begin
        equal = (a == b);
        a_nxt = a;
        b_nxt = b;
        if (!equal) begin
            if (!a[0]) begin
                a_nxt = a >> 1;
            end else if (!b[0]) begin
                b_nxt = b >> 1;
            end else if (a > b) begin
                // Both odd: the difference is even, so halving it loses nothing.
                a_nxt = (a - b) >> 1;
            end else begin
                b_nxt = (b - a) >> 1;
            end
        end
    end

endmodule

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD, one step per clock, start/done handshake.
// Optional 16-bit cycle counter output enabled by defining GCD_PERF_EN.
module gcd_stein
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    a_in,
    input  logic [WIDTH-1:0]    b_in,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                zero_err
`ifdef GCD_PERF_EN
    ,
    output logic [CYCLES_W-1:0] cycles
`endif
);

    gcd_state_t       state, state_nxt;
    logic [WIDTH-1:0] a, b;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_step, b_step;
    logic             equal;
    logic             load, zero_op, both_even;

    assign load      = (state == IDLE) && start;
    assign zero_op   = (a_in == '0) || (b_in == '0);
    assign both_even = !a[0] && !b[0];

    gcd_stein_step #(.WIDTH(WIDTH)) u_step (
        .a     (a),
        .b     (b),
        .a_nxt (a_step),
        .b_nxt (b_step),
        .equal (equal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_op ? DONE : STRIP;
            STRIP:   if (!both_even) state_nxt = REDUCE;
            REDUCE:  if (equal) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Working registers carry no reset: they are always reloaded before use.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    a <= a_in;
                    b <= b_in;
                    k <= '0;
                end
            end
            STRIP: begin
                if (both_even) begin
                    a <= a >> 1;
                    b <= b >> 1;
                    k <= k + 1'b1;
                end
            end
            REDUCE: begin
                a <= a_step;
                b <= b_step;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            result   <= '0;
            zero_err <= 1'b0;
        end else if (load && zero_op) begin
            result   <= a_in | b_in;
            zero_err <= ((a_in | b_in) == '0);
        end else if ((state == REDUCE) && equal) begin
            result   <= a << k;
            zero_err <= 1'b0;
        end
    end

`ifdef GCD_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycles <= '0;
        end else if (load) begin
            cycles <= '0;
        end else if (((state == STRIP) || (state == REDUCE)) && (cycles != '1)) begin
            cycles <= cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein at WIDTH=32 and WIDTH=16 against a Euclid model.
module tb_gcd_stein;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0, start16 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy32, done32, zerr32;
    logic        busy16, done16, zerr16;
    logic [31:0] res32;
    logic [15:0] res16;
    logic [15:0] cyc32, cyc16;

    int n_vec = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gcd_stein #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .a_in(a32), .b_in(b32),
        .busy(busy32), .done(done32), .result(res32), .zero_err(zerr32)
`ifdef GCD_PERF_EN
        , .cycles(cyc32)
`endif
    );

    gcd_stein #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .result(res16), .zero_err(zerr16)
`ifdef GCD_PERF_EN
        , .cycles(cyc16)
`endif
    );

`ifndef GCD_PERF_EN
    assign cyc32 = '0;
    assign cyc16 = '0;
`endif

    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic sel_done(input bit w16);
        return w16 ? done16 : done32;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, waits for done; lat is the cycle (after the start edge) in which done is seen.
    task automatic run_op(input bit w16, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic zerr, output int lat,
                          output logic [15:0] cyc, output logic done_after);
        tick();
        if (w16) begin a16 = a[15:0]; b16 = b[15:0]; start16 = 1'b1; end
        else     begin a32 = a;       b32 = b;       start32 = 1'b1; end
        tick();
        start16 = 1'b0;
        start32 = 1'b0;
        lat = 1;
        while (!sel_done(w16) && lat < 300) begin
            tick();
            lat++;
        end
        res  = w16 ? {16'h0, res16} : res32;
        zerr = w16 ? zerr16 : zerr32;
        cyc  = w16 ? cyc16 : cyc32;
        tick();
        done_after = sel_done(w16);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({busy32, done32, zerr32, busy16, done16, zerr16} !== 6'b0 || res32 !== 32'h0 || res16 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy/done/zerr32=%b%b%b 16=%b%b%b res32=%h res16=%h, need all zero",
                     busy32, done32, zerr32, busy16, done16, zerr16, res32, res16);
        end
`ifdef GCD_PERF_EN
        n_vec++;
        if (cyc32 !== 16'h0) begin n_fail++; $display("FAIL reset_cycles: got %0d need 0", cyc32); end
`endif
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] r; logic z, da; int lat; logic [15:0] c;
        run_op(1'b0, 32'd12, 32'd8, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd4 || z !== 1'b0) begin n_fail++; $display("FAIL basic_12_8: result=%0d zerr=%b need 4/0", r, z); end
        n_vec++;
        if (lat !== 7) begin n_fail++; $display("FAIL basic_latency: done at cycle %0d need 7", lat); end
        n_vec++;
        if (da !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: done still %b next cycle need 0", da); end
`ifdef GCD_PERF_EN
        n_vec++;
        if (c !== 16'd6) begin n_fail++; $display("FAIL basic_cycles: got %0d need 6", c); end
`endif
    endtask

    task automatic test_zero();
        logic [31:0] r; logic z, da; int lat; logic [15:0] c;
        run_op(1'b0, 32'd0, 32'd35, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd35 || z !== 1'b0 || lat !== 1) begin
            n_fail++; $display("FAIL zero_one: result=%0d zerr=%b lat=%0d need 35/0/1", r, z, lat);
        end
`ifdef GCD_PERF_EN
        n_vec++;
        if (c !== 16'd0) begin n_fail++; $display("FAIL zero_cycles: got %0d need 0", c); end
`endif
        run_op(1'b0, 32'd0, 32'd0, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
            n_fail++; $display("FAIL zero_both: result=%0d zerr=%b lat=%0d need 0/1/1", r, z, lat);
        end
        n_vec++;
        if (zerr32 !== 1'b1) begin n_fail++; $display("FAIL zero_hold: zerr=%b after done need 1", zerr32); end
        run_op(1'b1, 32'd14, 32'd0, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd14 || z !== 1'b0) begin n_fail++; $display("FAIL zero_w16: result=%0d zerr=%b need 14/0", r, z); end
    endtask

    task automatic test_extremes();
        logic [31:0] r; logic z, da; int lat; logic [15:0] c;
        run_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0000, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd1 || lat > 98) begin n_fail++; $display("FAIL ext_ones: result=%h lat=%0d need 1 within 98", r, lat); end
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'h8000_0000 || lat !== 34) begin
            n_fail++; $display("FAIL ext_pow2: result=%h lat=%0d need 80000000 at 34", r, lat);
        end
        run_op(1'b1, 32'h0000_FFFF, 32'h0000_8000, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd1 || lat > 50) begin n_fail++; $display("FAIL ext_w16: result=%h lat=%0d need 1 within 50", r, lat); end
    endtask

    task automatic test_busy_start();
        int ndone, lat;
        logic [31:0] r;
        tick();
        a32 = 32'd100; b32 = 32'd75; start32 = 1'b1;
        tick();
        a32 = 32'd9; b32 = 32'd6;
        ndone = 0; lat = 0; r = '0;
        for (int i = 1; i <= 12; i++) begin
            if (i > 3) start32 = 1'b0;
            if (done32) begin ndone++; lat = i; r = res32; end
            tick();
        end
        start32 = 1'b0;
        n_vec++;
        if (r !== 32'd25 || ndone !== 1 || lat !== 6) begin
            n_fail++; $display("FAIL busy_start: result=%0d dones=%0d lat=%0d need 25/1/6", r, ndone, lat);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r; logic z, da; int lat; logic [15:0] c;
        tick();
        a32 = 32'd100; b32 = 32'd75; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        tick();
        tick();
        n_vec++;
        if (busy32 !== 1'b1) begin n_fail++; $display("FAIL abort_busy: busy=%b mid-op need 1", busy32); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_vec++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0) begin
            n_fail++; $display("FAIL abort_reset: busy=%b done=%b result=%0d need 0/0/0", busy32, done32, res32);
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (done32 !== 1'b0) begin n_fail++; $display("FAIL abort_nodone: done=%b at %0d need 0", done32, i); end
            tick();
        end
        run_op(1'b0, 32'd21, 32'd14, r, z, lat, c, da);
        n_vec++;
        if (r !== 32'd7 || z !== 1'b0) begin n_fail++; $display("FAIL abort_next: result=%0d need 7", r); end
    endtask

    task automatic test_random(input bit w16);
        logic [31:0] r, x, y, m, exp; logic z, da; int lat, bound, s; logic [15:0] c;
        m = w16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        bound = w16 ? 50 : 98;
        for (int i = 0; i < 10; i++) begin
            x = $urandom; y = $urandom;
            if (i % 2 == 1) begin
                s = $urandom_range(1, 10);
                x = (x >> 20) << s;
                y = (y >> 20) << s;
            end
            x = x & m; y = y & m;
            if (x == 0) x = 32'd6;
            if (y == 0) y = 32'd9;
            exp = ref_gcd(x, y);
            run_op(w16, x, y, r, z, lat, c, da);
            n_vec++;
            if (r !== exp || z !== 1'b0 || lat > bound || da !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_w%0d: gcd(%0d,%0d) result=%0d zerr=%b lat=%0d need %0d/0 within %0d",
                         w16 ? 16 : 32, x, y, r, z, lat, exp, bound);
            end
`ifdef GCD_PERF_EN
            n_vec++;
            if (c !== 16'(lat - 1)) begin
                n_fail++; $display("FAIL rand_cycles: got %0d need %0d", c, lat - 1);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_extremes();
        test_busy_start();
        test_abort();
        test_random(1'b1);
        test_random(1'b0);
        n_vec++;
        if (busy16 !== 1'b0 || busy32 !== 1'b0) begin
            n_fail++; $display("FAIL final_idle: busy16=%b busy32=%b need 0/0", busy16, busy32);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
